serial_adder_8bit: RTL

//  Bit-serial, LSB-first two-operand adder with a start/busy/done handshake.

---
 rtl/serial_adder_8bit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_adder_8bit.sv
// ---------------------------------------------------------------------------
// serial_adder_8bit
//   Bit-serial, LSB-first adder: sum = a + b mod 2**WIDTH, one bit per clock.
//   start/busy/done handshake; result, and flags if built, held until the
//   next completion.
//   Optional feature macro: SERIAL_ADD_FLAGS_EN adds the cout and ovf outputs.
// ---------------------------------------------------------------------------
module serial_adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum
`ifdef SERIAL_ADD_FLAGS_EN
    ,
    output logic             cout,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             load;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             carry_next;

    // The single full-adder cell working on the current LSBs.
    assign bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Next-state and operand-load decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        next_state = state;
        load       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                    load       = 1'b1;
                end
            end
            S_RUN: begin
                if (last_bit) next_state = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    next_state = S_RUN;
                    load       = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the edge.
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Datapath: operand load, serial add/shift, and result capture on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
`ifdef SERIAL_ADD_FLAGS_EN
            cout  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {bit_s, r_sh[WIDTH-1:1]};
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= {bit_s, r_sh[WIDTH-1:1]};
`ifdef SERIAL_ADD_FLAGS_EN
                // carry here is the carry into the MSB.
                cout <= carry_next;
                ovf  <= carry ^ carry_next;
`endif
            end
        end
    end

endmodule
